tail_light_ctrl: RTL and testbench
==================================

# tail_light_ctrl

Sequential turn-signal/hazard controller for a six-lamp rear light cluster in the Thunderbird style: three lamps per side, LA/RA innermost and LC/RC outermost. A single Moore state machine sweeps the left or right lamps outward on a turn request, and flashes all six lamps for hazard. It sits between the driver-control inputs and the lamp drivers and is the only consumer of those inputs.

## Interface
- TICK_DIV, default 1: number of clk cycles per light step. Legal range ≥1. A 1-cycle tick pulse is generated internally.
- clk  input  1  system clock; all state changes occur on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- LEFT  input  1  left turn request, level-sensitive.
- RIGHT  input  1  right turn request, level-sensitive.
- HAZ  input  1  hazard request, level-sensitive.
- LC, LB, LA  output  1 each  left lamps, outer to inner; 1 = lit.
- RA, RB, RC  output  1 each  right lamps, inner to outer; 1 = lit.

## Operation
- States: IDLE, L1, L2, L3, R1, R2, R3, LR3.
- Outputs are decoded from the state register only (Moore); no combinational path from inputs to outputs.
  - IDLE: all six lamps 0.
  - L1: LA. L2: LA, LB. L3: LA, LB, LC. Right lamps 0 in all L states.
  - R1: RA. R2: RA, RB. R3: RA, RB, RC. Left lamps 0 in all R states.
  - LR3: all six lamps 1.
- Transitions are evaluated only on a tick:
  - IDLE: if HAZ, or LEFT and RIGHT together, go to LR3. Else if LEFT, go to L1. Else if RIGHT, go to R1. Else stay in IDLE.
  - L1 goes to L2, and L2 goes to L3. HAZ forces LR3 from either. LEFT/RIGHT are ignored mid-sequence; the sweep always completes.
  - L3 goes to IDLE unconditionally.
  - R1, R2 and R3 follow the same rules as L1, L2 and L3.
  - LR3 goes to IDLE unconditionally. Held hazard therefore blinks all-on/all-off with a period of 2 ticks.
- A held LEFT repeats the pattern 001, 011, 111, 000 on {LC,LB,LA} with a period of 4 ticks. RIGHT behaves the same on {RC,RB,RA}.
- Illegal or unreachable state encodings go to IDLE on the next tick.

## Timing
- Reset (rst_n=0): state becomes IDLE immediately, asynchronously. All outputs are 0. The tick divider counter clears to 0.
- After reset release, the first tick occurs TICK_DIV rising edges later. With TICK_DIV=1, every rising edge is a tick.
- Latency: a request present at a tick edge while in IDLE lights the first pattern on that same edge's registered output (1 tick).
- Input changes between ticks have no effect; only values at the tick edge matter.
- Reset asserted mid-sequence aborts it. Lamps are dark immediately and the FSM restarts from IDLE.
- Simultaneous requests follow the priority HAZ > (LEFT & RIGHT) > LEFT > RIGHT.

## Test plan
- Reset: drive rst_n=0 with LEFT=1 → all outputs 0 immediately and throughout. Release → {LC,LB,LA} = 001 after the first edge (TICK_DIV=1).
- Left sweep: LEFT=1, RIGHT=0, HAZ=0 for 10 cycles → {LC,LB,LA} = 001, 011, 111, 000, repeating. {RA,RB,RC} stay 000.
- Switch mid-sweep: after the left test, drive LEFT=0, RIGHT=1 while in L2 → L3 (111), then 000, then {RC,RB,RA} = 001, 011, 111, 000, repeating.
- Hazard: LEFT=0, RIGHT=0, HAZ=1 from IDLE → all six lamps 1, 0, 1, 0 on alternate cycles.
- Hazard priority: LEFT=1, HAZ=1 → only the LR3/IDLE alternation, never a partial left pattern. HAZ asserted in L1 → LR3 on the next edge. LEFT=RIGHT=1 with HAZ=0 → same as hazard.
- Divider: TICK_DIV=3 with LEFT=1 → each pattern held exactly 3 cycles. Pulse rst_n low mid-step → outputs 0 at once, and the divider restarts.

Source files
------------

// File: rtl/tail_light_ctrl_if.sv
// ---------------------------------------------------------------------------
// tail_light_ctrl_if
// Bundle of driver-control requests and lamp-driver outputs for the
// Thunderbird-style rear light cluster.
//   LEFT, RIGHT, HAZ : level-sensitive requests (master -> slave)
//   LC, LB, LA       : left lamps, outer to inner (slave -> master)
//   RA, RB, RC       : right lamps, inner to outer (slave -> master)
// ---------------------------------------------------------------------------
interface tail_light_ctrl_if;
  logic LEFT;
  logic RIGHT;
  logic HAZ;
  logic LC;
  logic LB;
  logic LA;
  logic RA;
  logic RB;
  logic RC;

  // Driver-control side: issues requests, observes lamps.
  modport master (
    output LEFT, RIGHT, HAZ,
    input  LC, LB, LA, RA, RB, RC
  );

  // Controller side: consumes requests, drives lamps.
  modport slave (
    input  LEFT, RIGHT, HAZ,
    output LC, LB, LA, RA, RB, RC
  );
endinterface

// File: rtl/tail_light_ctrl.sv
// ---------------------------------------------------------------------------
// tail_light_ctrl
// Sequential turn-signal / hazard controller for a six-lamp rear cluster.
// A Moore FSM sweeps the left or right lamps outward on a turn request and
// flashes all six lamps for hazard. State advances only on an internal
// 1-cycle tick generated every TICK_DIV clock cycles.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   lights : slave modport of tail_light_ctrl_if (requests in, lamps out)
// ---------------------------------------------------------------------------
module tail_light_ctrl #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  tail_light_ctrl_if.slave   lights
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    L1   = 3'd1,
    L2   = 3'd2,
    L3   = 3'd3,
    R1   = 3'd4,
    R2   = 3'd5,
    R3   = 3'd6,
    LR3  = 3'd7
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;
  logic [5:0]    lamps;   // {LC, LB, LA, RA, RB, RC}

  // -------------------------------------------------------------------------
  // Tick divider: tick is high while the counter sits at its terminal value,
  // so the first tick lands on the TICK_DIV-th edge after reset release.
  // -------------------------------------------------------------------------
  always_comb begin
    tick  = (cnt_q == CW'(TICK_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    if (tick) begin
      case (state_q)
        IDLE: begin
          // Priority: HAZ > (LEFT & RIGHT) > LEFT > RIGHT.
          if (lights.HAZ || (lights.LEFT && lights.RIGHT)) state_d = LR3;
          else if (lights.LEFT)                            state_d = L1;
          else if (lights.RIGHT)                           state_d = R1;
          else                                             state_d = IDLE;
        end
        // Turn requests are ignored mid-sweep; only hazard can cut it short.
        L1:      state_d = lights.HAZ ? LR3 : L2;
        L2:      state_d = lights.HAZ ? LR3 : L3;
        L3:      state_d = IDLE;
        R1:      state_d = lights.HAZ ? LR3 : R2;
        R2:      state_d = lights.HAZ ? LR3 : R3;
        R3:      state_d = IDLE;
        LR3:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State and divider registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Moore output decode: lamps depend on the state register only.
  // -------------------------------------------------------------------------
  always_comb begin
    lamps = 6'b000_000;
    case (state_q)
      L1:      lamps = 6'b001_000;
      L2:      lamps = 6'b011_000;
      L3:      lamps = 6'b111_000;
      R1:      lamps = 6'b000_100;
      R2:      lamps = 6'b000_110;
      R3:      lamps = 6'b000_111;
      LR3:     lamps = 6'b111_111;
      default: lamps = 6'b000_000;
    endcase
  end

  assign lights.LC = lamps[5];
  assign lights.LB = lamps[4];
  assign lights.LA = lamps[3];
  assign lights.RA = lamps[2];
  assign lights.RB = lamps[1];
  assign lights.RC = lamps[0];

endmodule

// File: tb/tb_tail_light_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tail_light_ctrl
// Drives two controllers (TICK_DIV=1 and TICK_DIV=3) from the same request
// lines. A sequence-level model predicts the lamp vector {LC,LB,LA,RA,RB,RC}
// for each instance; a compare process checks both every falling edge, and
// directed literal checks pin the model at the interesting points.
// ---------------------------------------------------------------------------
module tb_tail_light_ctrl;

  logic clk;
  logic rst_n;
  logic left, right, haz;

  int n_checks = 0;
  int n_fail   = 0;

  tail_light_ctrl_if if1 ();
  tail_light_ctrl_if if3 ();

  assign if1.LEFT  = left;
  assign if1.RIGHT = right;
  assign if1.HAZ   = haz;
  assign if3.LEFT  = left;
  assign if3.RIGHT = right;
  assign if3.HAZ   = haz;

  tail_light_ctrl #(.TICK_DIV(1)) u_div1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .lights (if1.slave)
  );

  tail_light_ctrl #(.TICK_DIV(3)) u_div3 (
    .clk    (clk),
    .rst_n  (rst_n),
    .lights (if3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [5:0] lamps1 = {if1.LC, if1.LB, if1.LA, if1.RA, if1.RB, if1.RC};
  wire [5:0] lamps3 = {if3.LC, if3.LB, if3.LA, if3.RA, if3.RB, if3.RC};

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Model: each instance is either idle or playing a pattern sequence
  // (mode 1 = left sweep, 2 = right sweep, 3 = hazard flash) at position pos.
  // -------------------------------------------------------------------------
  int m_div  [2] = '{1, 3};
  int m_cnt  [2];
  int m_mode [2];
  int m_pos  [2];

  function automatic logic [5:0] expect_lamps(input int mode, input int pos);
    logic [2:0] s;
    s = 3'((1 << (pos + 1)) - 1);   // lamps lit from the inside out
    case (mode)
      1:       return {s, 3'b000};
      2:       return {3'b000, s[0], s[1], s[2]};
      3:       return 6'b111_111;
      default: return 6'b000_000;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_cnt[k]  <= 0;
        m_mode[k] <= 0;
        m_pos[k]  <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int mo, po;
        mo = m_mode[k];
        po = m_pos[k];
        if (m_cnt[k] == m_div[k] - 1) begin
          m_cnt[k] <= 0;
          case (mo)
            0: begin
              if (haz || (left && right)) begin mo = 3; po = 0; end
              else if (left)              begin mo = 1; po = 0; end
              else if (right)             begin mo = 2; po = 0; end
            end
            1, 2: begin
              if (po < 2 && haz) begin mo = 3; po = 0; end
              else if (po == 2)  begin mo = 0; po = 0; end
              else               po = po + 1;
            end
            default: begin mo = 0; po = 0; end
          endcase
          m_mode[k] <= mo;
          m_pos[k]  <= po;
        end else begin
          m_cnt[k] <= m_cnt[k] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("model_div1", lamps1, expect_lamps(m_mode[0], m_pos[0]));
    check("model_div3", lamps3, expect_lamps(m_mode[1], m_pos[1]));
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Assert reset mid-cycle, confirm lamps go dark at once, release on the
  // next falling edge so the following rising edge is edge 1.
  task automatic pulse_reset(input string name);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check({name, "_div1"}, lamps1, 6'b000_000);
    check({name, "_div3"}, lamps3, 6'b000_000);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    left  = 1'b1;
    right = 1'b0;
    haz   = 1'b0;

    // Reset held with LEFT asserted: dark throughout.
    cyc(3);
    check("reset_hold_div1", lamps1, 6'b000_000);
    check("reset_hold_div3", lamps3, 6'b000_000);
    rst_n = 1'b1;

    // Left sweep.
    cyc(1);  check("left_first", lamps1, 6'b001_000);
    cyc(1);  check("left_l2",    lamps1, 6'b011_000);
    cyc(1);  check("left_l3",    lamps1, 6'b111_000);
    cyc(1);  check("left_idle",  lamps1, 6'b000_000);
    cyc(6);  check("left_l2_again", lamps1, 6'b011_000);

    // Switch to right while in L2: sweep completes first.
    left  = 1'b0;
    right = 1'b1;
    cyc(1);  check("switch_l3",   lamps1, 6'b111_000);
    cyc(1);  check("switch_idle", lamps1, 6'b000_000);
    cyc(1);  check("right_r1",    lamps1, 6'b000_100);
    cyc(1);  check("right_r2",    lamps1, 6'b000_110);
    cyc(1);  check("right_r3",    lamps1, 6'b000_111);
    cyc(1);  check("right_idle",  lamps1, 6'b000_000);
    cyc(4);

    // Hazard from IDLE.
    right = 1'b0;
    haz   = 1'b1;
    pulse_reset("rst_haz");
    cyc(1);  check("haz_on0",  lamps1, 6'b111_111);
    cyc(1);  check("haz_off0", lamps1, 6'b000_000);
    cyc(1);  check("haz_on1",  lamps1, 6'b111_111);
    cyc(1);  check("haz_off1", lamps1, 6'b000_000);

    // Hazard beats a simultaneous left request.
    left = 1'b1;
    pulse_reset("rst_prio");
    cyc(1);  check("prio_on", lamps1, 6'b111_111);
    cyc(7);

    // Hazard arriving in L1 cuts the sweep short.
    haz = 1'b0;
    pulse_reset("rst_l1haz");
    cyc(1);  check("l1haz_l1", lamps1, 6'b001_000);
    haz  = 1'b1;
    left = 1'b0;
    cyc(1);  check("l1haz_lr3", lamps1, 6'b111_111);
    cyc(2);

    // LEFT and RIGHT together behave as hazard.
    haz   = 1'b0;
    left  = 1'b1;
    right = 1'b1;
    pulse_reset("rst_both");
    cyc(1);  check("both_on",  lamps1, 6'b111_111);
    cyc(1);  check("both_off", lamps1, 6'b000_000);
    cyc(3);

    // Divider: each pattern held for exactly three cycles.
    right = 1'b0;
    pulse_reset("rst_div");
    cyc(2);  check("div_wait",   lamps3, 6'b000_000);
    cyc(1);  check("div_l1_a",   lamps3, 6'b001_000);
    cyc(2);  check("div_l1_b",   lamps3, 6'b001_000);
    cyc(1);  check("div_l2",     lamps3, 6'b011_000);
    cyc(1);

    // Reset mid-step: divider restarts from zero.
    pulse_reset("rst_midstep");
    cyc(2);  check("div_restart_wait", lamps3, 6'b000_000);
    cyc(1);  check("div_restart_l1",   lamps3, 6'b001_000);
    cyc(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
